uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 53 +++++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_tx_cfg.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the configurable UART transmitter.
//   - tx_state_e  : transmitter FSM state encoding
//   - data_bits_e : cfg_data_bits encoding (5..8 data bits)
//   - parity_e    : cfg_parity encoding (none / even / odd / reserved)
//   - OVERSAMPLE_DEF : default number of baud ticks per serial bit
//   - data_mask / last_bit_idx : helpers derived from the data-bits encoding
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        BITS_5 = 2'b00,
        BITS_6 = 2'b01,
        BITS_7 = 2'b10,
        BITS_8 = 2'b11
    } data_bits_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    // Mask that keeps only the data bits actually transmitted.
    function automatic logic [7:0] data_mask(input data_bits_e bits);
        case (bits)
            BITS_5:  return 8'h1F;
            BITS_6:  return 8'h3F;
            BITS_7:  return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

    // Index of the last data bit of a frame (N-1).
    function automatic logic [2:0] last_bit_idx(input data_bits_e bits);
        case (bits)
            BITS_5:  return 3'd4;
            BITS_6:  return 3'd5;
            BITS_7:  return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: baud tick generator.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset, clears the counter
//   restart : forces the counter back to 0 on this edge (frame load)
//   div     : tick period minus one, in clk cycles
//   tick    : high during the cycle in which the count equals div
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with a 1-entry holding
// register in front of the shift register.
//   clk, reset     : clock and synchronous active-high reset
//   cfg_div        : baud tick period minus one (clk cycles)
//   cfg_data_bits  : 00=5 .. 11=8 data bits
//   cfg_parity     : 00 none, 01 even, 10 odd, 11 none
//   cfg_stop2      : 1 selects two stop bits
//   s_valid/s_data/s_ready : byte input handshake
//   tx             : registered serial output, idle high
//   busy           : frame in progress or byte waiting in the holding register
//   tx_done        : one-cycle pulse after the final stop bit of each frame
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    tx_state_e        state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    data_bits_e       bits_q, bits_d;
    parity_e          parity_q, parity_d;
    logic             stop2_q, stop2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             tick;
    logic             bit_end;
    logic             frame_end;
    logic             accept;
    logic             load;
    logic [7:0]       load_data;
    data_bits_e       cfg_bits_e;
    parity_e          cfg_par_e;

    assign cfg_bits_e = data_bits_e'(cfg_data_bits);
    assign cfg_par_e  = parity_e'(cfg_parity);

    // The counter restarts on every load so the start bit is full length.
    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (load),
        .div     (div_q),
        .tick    (tick)
    );

    assign bit_end   = tick && (os_cnt_q == OS_LAST) && (state_q != ST_IDLE);
    assign frame_end = bit_end && (state_q == ST_STOP) && (!stop2_q || stop_idx_q);
    assign accept    = s_valid && !hold_full_q;
    // A waiting byte starts from IDLE, or directly after the last stop bit.
    assign load      = hold_full_q && ((state_q == ST_IDLE) || frame_end);
    assign load_data = hold_q & data_mask(cfg_bits_e);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        par_d       = par_q;
        bits_d      = bits_q;
        parity_d    = parity_q;
        stop2_d     = stop2_q;
        div_d       = div_q;
        os_cnt_d    = os_cnt_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        done_d      = 1'b0;

        if ((state_q != ST_IDLE) && tick) begin
            os_cnt_d = bit_end ? '0 : os_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == last_bit_idx(bits_q)) begin
                        state_d    = ((parity_q == PAR_EVEN) || (parity_q == PAR_ODD)) ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (frame_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (bit_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Config is sampled only here so mid-frame changes wait for the next frame.
        if (load) begin
            state_d     = ST_START;
            shift_d     = load_data;
            par_d       = (^load_data) ^ (cfg_par_e == PAR_ODD);
            bits_d      = cfg_bits_e;
            parity_d    = cfg_par_e;
            stop2_d     = cfg_stop2;
            div_d       = cfg_div;
            os_cnt_d    = '0;
            bit_idx_d   = 3'd0;
            stop_idx_d  = 1'b0;
            hold_full_d = 1'b0;
        end

        // Accept after load so a simultaneous accept leaves the register full.
        if (accept) begin
            hold_d      = s_data;
            hold_full_d = 1'b1;
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE) || hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_full_q <= 1'b0;
            bits_q      <= BITS_5;
            parity_q    <= PAR_NONE;
            stop2_q     <= 1'b0;
            div_q       <= '0;
            os_cnt_q    <= '0;
            bit_idx_q   <= 3'd0;
            stop_idx_q  <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            bits_q      <= bits_d;
            parity_q    <= parity_d;
            stop2_q     <= stop2_d;
            div_q       <= div_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
        hold_q  <= hold_d;
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign s_ready = !hold_full_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg. Expected serial
// waveforms come from a frame-level model: the list of frame bits for a byte
// and configuration, each repeated for OVERSAMPLE*(div+1) cycles.
module tb_uart_tx_cfg;

    localparam int OS = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] cfg_div = '0;
    logic [1:0]    cfg_data_bits = 2'b11;
    logic [1:0]    cfg_parity = 2'b00;
    logic          cfg_stop2 = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_ready;
    logic          tx;
    logic          busy;
    logic          tx_done;

    int total = 0;
    int bad = 0;

    bit cap_tx[$];
    bit cap_done[$];
    bit cap_rdy[$];
    bit exp_tx[$];
    bit exp_done[$];
    bit pend_done = 1'b0;

    uart_tx_cfg #(
        .OVERSAMPLE (OS),
        .DIV_W      (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .tx            (tx),
        .busy          (busy),
        .tx_done       (tx_done)
    );

    always #5 clk = ~clk;

    task automatic sample();
        cap_tx.push_back(tx);
        cap_done.push_back(tx_done);
        cap_rdy.push_back(s_ready);
    endtask

    task automatic step();
        @(negedge clk);
        sample();
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_all();
        cap_tx.delete(); cap_done.delete(); cap_rdy.delete();
        exp_tx.delete(); exp_done.delete();
        pend_done = 1'b0;
    endtask

    task automatic mpush(input bit v);
        exp_tx.push_back(v);
        exp_done.push_back(pend_done);
        pend_done = 1'b0;
    endtask

    // Frame-level model: start, N data bits LSB first, optional parity, stops.
    task automatic model_frame(input logic [7:0] d, input int bits, input int par, input bit stop2, input int div);
        bit fb[$];
        int n = 5 + bits;
        int ones = 0;
        fb.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            fb.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 1) fb.push_back(bit'(ones % 2));
        else if (par == 2) fb.push_back(bit'(1 - ones % 2));
        fb.push_back(1'b1);
        if (stop2) fb.push_back(1'b1);
        foreach (fb[j]) begin
            for (int c = 0; c < OS * (div + 1); c++) mpush(fb[j]);
        end
        pend_done = 1'b1;
    endtask

    task automatic model_idle(input int n);
        for (int i = 0; i < n; i++) mpush(1'b1);
    endtask

    // Counts sample mismatches between captured and modelled waveforms.
    task automatic wave_errs(output int etx, output int edone, output int first);
        etx = 0; edone = 0; first = -1;
        for (int i = 0; i < exp_tx.size(); i++) begin
            if (i >= cap_tx.size()) begin
                etx++; edone++;
                if (first < 0) first = i;
            end else begin
                if (cap_tx[i] != exp_tx[i]) begin
                    etx++;
                    if (first < 0) first = i;
                end
                if (cap_done[i] != exp_done[i]) begin
                    edone++;
                    if (first < 0) first = i;
                end
            end
        end
    endtask

    task automatic done_stats(output int cnt, output int first_idx);
        cnt = 0; first_idx = -1;
        foreach (cap_done[i]) begin
            if (cap_done[i]) begin
                cnt++;
                if (first_idx < 0) first_idx = i;
            end
        end
    endtask

    task automatic set_cfg(input int div, input int bits, input int par, input bit stop2);
        cfg_div       = DW'(div);
        cfg_data_bits = 2'(bits);
        cfg_parity    = 2'(par);
        cfg_stop2     = stop2;
    endtask

    // Called and returns at a negedge; afterwards the accept edge has passed.
    task automatic send_byte(input logic [7:0] d);
        int guard = 0;
        while (s_ready !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            total++; bad++;
            $display("FAIL send_wait: s_ready stayed %b, required 1 within 5000 cycles", s_ready);
        end
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_valid = 1'b1;
        s_data = 8'hA5;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", s_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
        s_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: tx=%b busy=%b want tx=1 busy=0", tx, busy); end
    endtask

    task automatic test_8n1();
        int etx, edone, first, cnt, fidx;
        set_cfg(0, 3, 0, 1'b0);
        @(negedge clk);
        clear_all();
        send_byte(8'h55);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL 8n1_tx_accept_cycle: got %b want 1", tx); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL 8n1_ready_accept_cycle: got %b want 0", s_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL 8n1_busy_accept_cycle: got %b want 1", busy); end
        capture(163);
        model_frame(8'h55, 3, 0, 1'b0, 0);
        model_idle(3);
        wave_errs(etx, edone, first);
        done_stats(cnt, fidx);
        total++; if (cap_rdy[0] !== 1'b1) begin bad++; $display("FAIL 8n1_ready_after_load: got %b want 1", cap_rdy[0]); end
        total++; if (etx != 0) begin bad++; $display("FAIL 8n1_wave: %0d tx samples differ (first at %0d), want 0", etx, first); end
        total++; if (edone != 0) begin bad++; $display("FAIL 8n1_done_wave: %0d tx_done samples differ, want 0", edone); end
        total++; if (fidx != 160) begin bad++; $display("FAIL 8n1_frame_len: got %0d cycles want 160", fidx); end
        total++; if (cnt != 1) begin bad++; $display("FAIL 8n1_done_count: got %0d want 1", cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL 8n1_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_7e2();
        int etx, edone, first, cnt, fidx;
        set_cfg(3, 2, 1, 1'b1);
        clear_all();
        send_byte(8'h41);
        capture(707);
        model_frame(8'h41, 2, 1, 1'b1, 3);
        model_idle(3);
        wave_errs(etx, edone, first);
        done_stats(cnt, fidx);
        total++; if (etx != 0) begin bad++; $display("FAIL 7e2_wave: %0d tx samples differ (first at %0d), want 0", etx, first); end
        total++; if (fidx != 704) begin bad++; $display("FAIL 7e2_frame_len: got %0d cycles want 704", fidx); end
        total++; if (cnt != 1) begin bad++; $display("FAIL 7e2_done_count: got %0d want 1", cnt); end
    endtask

    task automatic test_5o1();
        int etx, edone, first, cnt, fidx;
        set_cfg(1, 0, 2, 1'b0);
        clear_all();
        send_byte(8'hFF);
        capture(259);
        model_frame(8'hFF, 0, 2, 1'b0, 1);
        model_idle(3);
        wave_errs(etx, edone, first);
        done_stats(cnt, fidx);
        total++; if (etx != 0) begin bad++; $display("FAIL 5o1_wave: %0d tx samples differ (first at %0d), want 0", etx, first); end
        total++; if (fidx != 256) begin bad++; $display("FAIL 5o1_frame_len: got %0d cycles want 256", fidx); end
    endtask

    task automatic test_random();
        int etx, edone, first, bits, par, div;
        bit stop2;
        logic [7:0] d;
        for (int it = 0; it < 8; it++) begin
            d     = 8'($urandom);
            bits  = int'($urandom_range(0, 3));
            par   = int'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            div   = int'($urandom_range(0, 2));
            set_cfg(div, bits, par, stop2);
            clear_all();
            send_byte(d);
            model_frame(d, bits, par, stop2, div);
            model_idle(3);
            capture(exp_tx.size());
            wave_errs(etx, edone, first);
            total++; if (etx != 0) begin bad++; $display("FAIL rand_wave[%0d]: data=%h bits=%0d par=%0d stop2=%0d div=%0d, %0d tx samples differ (first %0d), want 0", it, d, bits, par, stop2, div, etx, first); end
            total++; if (edone != 0) begin bad++; $display("FAIL rand_done[%0d]: %0d tx_done samples differ, want 0", it, edone); end
        end
    endtask

    task automatic test_back_to_back();
        int etx, edone, first, cnt, fidx, rerr;
        logic [7:0] a, b;
        bit want;
        a = 8'($urandom);
        b = 8'($urandom);
        set_cfg(0, 3, 0, 1'b0);
        @(negedge clk);
        clear_all();
        s_valid = 1'b1;
        s_data  = a;
        @(negedge clk);
        s_data = b;
        step();
        step();
        s_valid = 1'b0;
        capture(321);
        model_frame(a, 3, 0, 1'b0, 0);
        model_frame(b, 3, 0, 1'b0, 0);
        model_idle(3);
        wave_errs(etx, edone, first);
        done_stats(cnt, fidx);
        // Sample i is i+1 cycles after the first accept; B waits in the
        // holding register from cycle 2 until its load at cycle 161.
        rerr = 0;
        foreach (cap_rdy[i]) begin
            want = !((i + 1 >= 2) && (i + 1 <= 160));
            if (cap_rdy[i] != want) rerr++;
        end
        total++; if (etx != 0) begin bad++; $display("FAIL b2b_wave: %0d tx samples differ (first at %0d), want 0", etx, first); end
        total++; if (edone != 0) begin bad++; $display("FAIL b2b_done_wave: %0d tx_done samples differ, want 0", edone); end
        total++; if (cnt != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", cnt); end
        total++; if (rerr != 0) begin bad++; $display("FAIL b2b_ready: %0d s_ready samples differ, want 0", rerr); end
    endtask

    task automatic test_div_change();
        int etx, edone, first, cnt, fidx;
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        set_cfg(0, 3, 0, 1'b0);
        clear_all();
        send_byte(a);
        capture(40);
        cfg_div = DW'(5);
        s_valid = 1'b1;
        s_data  = b;
        step();
        s_valid = 1'b0;
        model_frame(a, 3, 0, 1'b0, 0);
        model_frame(b, 3, 0, 1'b0, 5);
        model_idle(3);
        capture(exp_tx.size() - 41);
        wave_errs(etx, edone, first);
        done_stats(cnt, fidx);
        total++; if (etx != 0) begin bad++; $display("FAIL divchg_wave: %0d tx samples differ (first at %0d), want 0", etx, first); end
        total++; if (fidx != 160) begin bad++; $display("FAIL divchg_first_len: got %0d cycles want 160", fidx); end
        total++; if (cnt != 2) begin bad++; $display("FAIL divchg_done_count: got %0d want 2", cnt); end
        cfg_div = '0;
    endtask

    task automatic test_reset_mid();
        int etx, edone, first, cnt, fidx;
        logic [7:0] c;
        set_cfg(0, 3, 1, 1'b0);
        clear_all();
        send_byte(8'h3C);
        capture(20);
        s_valid = 1'b1;
        s_data  = 8'hC3;
        step();
        s_valid = 1'b0;
        capture(20);
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rstmid_held: s_ready got %b want 0", s_ready); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", s_ready); end
        total++; if (busy !== 1'b0 || tx_done !== 1'b0) begin bad++; $display("FAIL rstmid_busy_done: busy=%b tx_done=%b want 0 0", busy, tx_done); end
        reset = 1'b0;
        clear_all();
        capture(200);
        model_idle(200);
        wave_errs(etx, edone, first);
        total++; if (etx != 0 || edone != 0) begin bad++; $display("FAIL rstmid_quiet: %0d tx and %0d tx_done samples differ from idle, want 0", etx, edone); end
        c = 8'($urandom);
        clear_all();
        send_byte(c);
        model_frame(c, 3, 1, 1'b0, 0);
        model_idle(3);
        capture(exp_tx.size());
        wave_errs(etx, edone, first);
        done_stats(cnt, fidx);
        total++; if (etx != 0) begin bad++; $display("FAIL rstmid_next_wave: %0d tx samples differ (first at %0d), want 0", etx, first); end
        total++; if (cnt != 1) begin bad++; $display("FAIL rstmid_next_done: got %0d want 1", cnt); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_5o1();
        test_random();
        test_back_to_back();
        test_div_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
